// File: rtl/fifo_buffer_mem.sv
// rtl/fifo_buffer_mem.sv - storage array for fifo_buffer_acc: one write port, async read, async clear
module fifo_buffer_mem #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   we,
  input  logic [BufferWidth-1:0] waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [BufferWidth-1:0] raddr,
  output logic [DataWidth-1:0]   rdata
);

  logic [DataWidth-1:0] mem [BufferSize];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < BufferSize; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer_acc.sv
// rtl/fifo_buffer_acc.sv - first-word-fall-through circular FIFO feeding the MAC accumulator
module fifo_buffer_acc #(
  parameter int DataWidth   = 32,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic [DataWidth-1:0] DataIn,
  output logic                 Empty,
  output logic                 Full,
  output logic [DataWidth-1:0] DataOut
);

  if (BufferSize != 2 ** BufferWidth) begin : g_size_check
    $fatal(1, "fifo_buffer_acc: BufferSize must equal 2**BufferWidth");
  end

  localparam logic [BufferWidth:0] FullCount = (BufferWidth + 1)'(BufferSize);

  logic [BufferWidth-1:0] wr_ptr;
  logic [BufferWidth-1:0] rd_ptr;
  logic [BufferWidth:0]   count;
  logic [DataWidth-1:0]   head;
  logic                   wr_en;
  logic                   rd_en;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en = Push & (~Full | Pop);
  assign rd_en = Pop & ~Empty;

  assign Empty   = (count == '0);
  assign Full    = (count == FullCount);
  assign DataOut = Empty ? '0 : head;

  fifo_buffer_mem #(
    .DataWidth  (DataWidth),
    .BufferWidth(BufferWidth),
    .BufferSize (BufferSize)
  ) u_mem (
    .clk  (clk),
    .aclr (aclr),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(DataIn),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + BufferWidth'(1);
      if (rd_en) rd_ptr <= rd_ptr + BufferWidth'(1);
      if (wr_en && !rd_en)      count <= count + (BufferWidth + 1)'(1);
      else if (rd_en && !wr_en) count <= count - (BufferWidth + 1)'(1);
    end
  end

endmodule

// File: tb/tb_fifo_buffer_acc.sv
// tb/tb_fifo_buffer_acc.sv - directed scoreboard bench for fifo_buffer_acc
module tb_fifo_buffer_acc;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          aclr;
  logic          Push;
  logic          Pop;
  logic [DW-1:0] DataIn;
  logic          Empty;
  logic          Full;
  logic [DW-1:0] DataOut;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sb [$];

  fifo_buffer_acc #(.DataWidth(DW), .BufferWidth(2), .BufferSize(DEPTH)) dut (
    .clk    (clk),
    .aclr   (aclr),
    .Push   (Push),
    .Pop    (Pop),
    .DataIn (DataIn),
    .Empty  (Empty),
    .Full   (Full),
    .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DW-1:0] exp_head;
    exp_head = (sb.size() == 0) ? '0 : sb[0];
    check({tag, ".empty"}, {31'd0, Empty}, {31'd0, sb.size() == 0});
    check({tag, ".full"},  {31'd0, Full},  {31'd0, sb.size() == DEPTH});
    check({tag, ".dout"},  DataOut, exp_head);
  endtask

  // Drive one clock cycle of requests; the scoreboard tracks the expected contents.
  task automatic step(input string tag, input logic push, input logic pop, input logic [DW-1:0] din);
    logic wr, rd;
    @(negedge clk);
    Push = push;
    Pop = pop;
    DataIn = din;
    wr = push && (sb.size() < DEPTH || pop);
    rd = pop && sb.size() > 0;
    if (rd) void'(sb.pop_front());
    if (wr) sb.push_back(din);
    @(posedge clk);
    #1;
    check_state(tag);
    Push = 1'b0;
    Pop = 1'b0;
  endtask

  initial begin
    aclr = 1'b1;
    Push = 1'b0;
    Pop = 1'b0;
    DataIn = '0;
    #12;
    check_state("reset_hold");
    @(negedge clk);
    aclr = 1'b0;
    step("idle_after_reset", 1'b0, 1'b0, 32'd0);

    for (int i = 1; i <= 4; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, DW'(i));
    step("overflow", 1'b1, 1'b0, 32'd5);
    check("overflow_head", DataOut, 32'd1);
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1, 32'd0);
    step("pop_empty", 1'b0, 1'b1, 32'd0);

    for (int i = 10; i <= 12; i++) step($sformatf("wpush%0d", i), 1'b1, 1'b0, DW'(i));
    step("wpop0", 1'b0, 1'b1, 32'd0);
    step("wpop1", 1'b0, 1'b1, 32'd0);
    for (int i = 13; i <= 16; i++) step($sformatf("wpush%0d", i), 1'b1, 1'b0, DW'(i));
    check("wrap_full", {31'd0, Full}, 32'd1);
    step("pushpop_full", 1'b1, 1'b1, 32'd17);
    check("pushpop_full_head", DataOut, 32'd13);
    for (int i = 0; i < 5; i++) step($sformatf("wdrain%0d", i), 1'b0, 1'b1, 32'd0);

    step("pushpop_empty", 1'b1, 1'b1, 32'd7);
    check("pushpop_empty_head", DataOut, 32'd7);
    step("mid_push8", 1'b1, 1'b0, 32'd8);
    step("mid_pushpop9", 1'b1, 1'b1, 32'd9);
    step("mid_push10", 1'b1, 1'b0, 32'd10);

    @(negedge clk);
    #2;
    aclr = 1'b1;
    sb.delete();
    #1;
    check_state("async_reset");
    @(negedge clk);
    aclr = 1'b0;
    step("post_reset_idle", 1'b0, 1'b0, 32'd0);
    step("post_reset_push", 1'b1, 1'b0, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
